// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit: RV32I funct3 width/sign codes
// for loads and stores, the controller state encoding, and the access
// legality check used when a request is accepted.
// No ports (package).
package lsu_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Controller state encoding
  typedef logic [2:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE = 3'd0;
  localparam lsu_state_t ST_RD   = 3'd1;
  localparam lsu_state_t ST_WAIT = 3'd2;
  localparam lsu_state_t ST_WR   = 3'd3;
  localparam lsu_state_t ST_RESP = 3'd4;

  // Returns 1 for an unsupported funct3 or a misaligned halfword/word.
  // funct3[1:0] gives the access size for every legal load and store code,
  // so alignment can be checked once the code itself is known to be legal.
  function automatic logic lsu_access_err(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    if (write) begin
      if (!(funct3 inside {F3_SB, F3_SH, F3_SW})) err = 1'b1;
    end else begin
      if (funct3 inside {3'b011, 3'b110, 3'b111}) err = 1'b1;
    end
    if (!err) begin
      case (funct3[1:0])
        2'b01:   err = addr_lo[0];
        2'b10:   err = (addr_lo != 2'b00);
        default: err = 1'b0;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Combinational lane logic for the load/store unit.
//   funct3      : RV32I width/sign code of the access
//   byte_off    : byte address bits [1:0]
//   mem_word    : word read from data RAM
//   store_data  : right-aligned store data
//   load_data   : selected lane, sign- or zero-extended (0 for illegal codes)
//   merged_data : mem_word with only the addressed lane replaced by store_data
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);
  import lsu_pkg::*;

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Little-endian lane selection: byte lane byte_off, halfword lane byte_off[1].
  always_comb begin
    sel_half = byte_off[1] ? mem_word[31:16] : mem_word[15:0];
    case (byte_off)
      2'd0:    sel_byte = mem_word[7:0];
      2'd1:    sel_byte = mem_word[15:8];
      2'd2:    sel_byte = mem_word[23:16];
      default: sel_byte = mem_word[31:24];
    endcase
  end

  // Load extension: signed codes replicate the lane's top bit.
  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      F3_LW:   load_data = mem_word;
      F3_LBU:  load_data = {24'h000000, sel_byte};
      F3_LHU:  load_data = {16'h0000, sel_half};
      default: load_data = 32'h0;
    endcase
  end

  // Store merge for read-modify-write: untouched lanes keep the RAM contents.
  always_comb begin
    merged_data = mem_word;
    case (funct3)
      F3_SB: begin
        case (byte_off)
          2'd0:    merged_data[7:0]   = store_data[7:0];
          2'd1:    merged_data[15:8]  = store_data[7:0];
          2'd2:    merged_data[23:16] = store_data[7:0];
          default: merged_data[31:24] = store_data[7:0];
        endcase
      end
      F3_SH: begin
        if (byte_off[1]) merged_data[31:16] = store_data[15:0];
        else             merged_data[15:0]  = store_data[15:0];
      end
      F3_SW:   merged_data = store_data;
      default: merged_data = mem_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// RV32I load/store unit in front of a single-port synchronous data RAM.
// Byte and halfword stores are done as read-modify-write; word stores write
// directly. Illegal or misaligned accesses answer with resp_err without
// touching the RAM.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   req_valid/req_ready : request handshake (ready only when idle)
//   req_write           : 1 = store, 0 = load
//   req_funct3          : RV32I width/sign code
//   req_addr, req_wdata : byte address, right-aligned store data
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : extended load data (0 for stores and errors)
//   resp_err            : misaligned/illegal access flag
//   mem_addr            : RAM word address (req_addr >> 2)
//   mem_write, mem_din  : RAM write strobe and data
//   mem_dout            : RAM read data, one cycle after the address
module load_store_unit #(
  parameter int WORD = 32,
  parameter int ADDR = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [ADDR-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  output logic [WORD-1:0] resp_rdata,
  output logic            resp_err,
  output logic [ADDR-1:0] mem_addr,
  output logic            mem_write,
  output logic [WORD-1:0] mem_din,
  input  logic [WORD-1:0] mem_dout
);
  import lsu_pkg::*;

  lsu_state_t      state;
  logic            write_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [WORD-1:0] wdata_q;
  logic [WORD-1:0] load_data;
  logic [WORD-1:0] merged_data;

  assign req_ready = (state == ST_IDLE);

  // Lane logic works on the live RAM output; it is only consumed in WAIT,
  // the one cycle in which mem_dout holds the addressed word.
  lsu_align u_align (
    .funct3      (funct3_q),
    .byte_off    (off_q),
    .mem_word    (mem_dout),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  // Controller. All outputs are registered and set on the transition into
  // the state that owns them, so mem_write is high exactly while in WR and
  // resp_valid exactly while in RESP. mem_addr is loaded once at accept and
  // then held until the unit is idle again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      write_q    <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_write  <= 1'b0;
      mem_din    <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      mem_write  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata;
            if (lsu_access_err(req_write, req_funct3, req_addr[1:0])) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_addr <= req_addr >> 2;
              if (req_write && req_funct3 == F3_SW) begin
                state     <= ST_WR;
                mem_write <= 1'b1;
                mem_din   <= req_wdata;
              end else begin
                state <= ST_RD;
              end
            end
          end
        end
        ST_RD: state <= ST_WAIT;
        ST_WAIT: begin
          if (write_q) begin
            state     <= ST_WR;
            mem_write <= 1'b1;
            mem_din   <= merged_data;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        ST_WR: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench: directed vector table, reset-abort sequence, and a
// randomized run compared against a byte-level reference memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int checks;
  int failures;

  load_store_unit #(.WORD(32), .ADDR(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous data RAM, 64 words; the bench preloads through pl_en
  logic [31:0] ram [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_val;
    else if (mem_write) ram[mem_addr[5:0]] <= mem_din;
    mem_dout <= ram[mem_addr[5:0]];
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  // Observations of one access
  int          obs_lat;
  logic [31:0] obs_rdata;
  logic        obs_err;
  int          obs_wr_cnt;
  int          obs_wr_lat;
  logic [31:0] obs_wr_din;
  logic        obs_addr_ok;
  logic        obs_post_valid;
  logic        obs_post_ready;

  // Expected values from the reference model
  logic [31:0] refmem [0:63];
  logic        exp_err;
  logic [31:0] exp_rdata;
  int          exp_lat;
  int          exp_wr_cnt;
  int          exp_wr_lat;
  logic [31:0] exp_din;

  typedef struct {
    logic        is_write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr_lat;
    logic [31:0] din;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = idx[5:0];
    pl_val = val;
    @(posedge clk); #1;
    pl_en  = 1'b0;
  endtask

  // Issue one request (called #1 after a rising edge with the unit idle) and
  // watch it until the response, sampling #1 after every edge. With noise set,
  // junk requests are driven while busy; the unit must ignore them.
  task automatic applyStimulus(input logic w, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic noise);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    obs_lat = 0; obs_wr_cnt = 0; obs_wr_lat = 0; obs_wr_din = 32'h0;
    obs_addr_ok = 1'b1; obs_rdata = 32'h0; obs_err = 1'b0;
    obs_post_valid = 1'b1; obs_post_ready = 1'b0;
    @(posedge clk); #1;
    if (noise) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_write  = 1'b1;
      req_funct3 = F3_SW;
      req_addr   = {24'h0, 6'($urandom), 2'b00};
      req_wdata  = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    for (int j = 1; j <= 20; j++) begin
      if (mem_write) begin
        obs_wr_cnt++;
        obs_wr_lat = j;
        obs_wr_din = mem_din;
      end
      if (mem_addr !== (a >> 2)) obs_addr_ok = 1'b0;
      if (resp_valid) begin
        obs_lat   = j;
        obs_rdata = resp_rdata;
        obs_err   = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (obs_lat != 0) begin
      @(posedge clk); #1;
      obs_post_valid = resp_valid;
      obs_post_ready = req_ready;
      if (mem_write) obs_wr_cnt++;
    end
  endtask

  // Reference model: byte-addressed memory semantics with plain arithmetic
  task automatic refModel(input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
    int sz;
    int off;
    int idx;
    logic [31:0] word;
    logic [31:0] v;
    sz  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    off = int'(a % 4);
    idx = int'(a / 4) % 64;
    if (w) exp_err = (f3 > 3'd2);
    else   exp_err = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (!exp_err && (off % sz) != 0) exp_err = 1'b1;
    exp_rdata = 32'h0; exp_wr_cnt = 0; exp_wr_lat = 0; exp_din = 32'h0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!w) begin
      exp_lat = 3;
      word = refmem[idx];
      if (sz == 4) begin
        v = word;
      end else if (sz == 2) begin
        v = (word >> (8 * off)) & 32'hFFFF;
        if (f3 < 4 && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else begin
        v = (word >> (8 * off)) & 32'hFF;
        if (f3 < 4 && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      exp_rdata = v;
    end else begin
      word = refmem[idx];
      for (int k = 0; k < sz; k++) begin
        word = (word & ~(32'hFF << (8 * (off + k)))) |
               (((wd >> (8 * k)) & 32'hFF) << (8 * (off + k)));
      end
      refmem[idx] = word;
      exp_din    = word;
      exp_wr_cnt = 1;
      exp_wr_lat = (sz == 4) ? 1 : 3;
      exp_lat    = (sz == 4) ? 2 : 4;
    end
  endtask

  initial begin
    int bad;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;

    checks = 0;
    failures = 0;
    pl_en = 1'b0; pl_idx = 6'd0; pl_val = 32'h0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;

    // Reset state
    rst_n = 1'b0;
    #12;
    checkOutput("reset req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("reset resp_err", {31'h0, resp_err}, 32'h0);
    checkOutput("reset mem_write", {31'h0, mem_write}, 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset mem_din", mem_din, 32'h0);
    checkOutput("reset resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table: hand-derived expectations
    vecs[0]  = '{1'b0, F3_LW,  32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3, 0, 32'h0};
    vecs[1]  = '{1'b0, F3_LB,  32'h13, 32'h0,        32'h80FF0011, 32'hFFFFFF80, 1'b0, 3, 0, 32'h0};
    vecs[2]  = '{1'b0, F3_LBU, 32'h13, 32'h0,        32'h80FF0011, 32'h00000080, 1'b0, 3, 0, 32'h0};
    vecs[3]  = '{1'b0, F3_LH,  32'h12, 32'h0,        32'h80FF0011, 32'hFFFF80FF, 1'b0, 3, 0, 32'h0};
    vecs[4]  = '{1'b0, F3_LHU, 32'h10, 32'h0,        32'h80FF0011, 32'h00000011, 1'b0, 3, 0, 32'h0};
    vecs[5]  = '{1'b1, F3_SH,  32'h22, 32'h0000ABCD, 32'h11223344, 32'h0,        1'b0, 4, 3, 32'hABCD3344};
    vecs[6]  = '{1'b1, F3_SB,  32'h21, 32'hFFFFFF5A, 32'h11223344, 32'h0,        1'b0, 4, 3, 32'h11225A44};
    vecs[7]  = '{1'b1, F3_SW,  32'h24, 32'hCAFEF00D, 32'h11223344, 32'h0,        1'b0, 2, 1, 32'hCAFEF00D};
    vecs[8]  = '{1'b0, F3_LW,  32'h06, 32'h0,        32'h12345678, 32'h0,        1'b1, 1, 0, 32'h0};
    vecs[9]  = '{1'b0, F3_LH,  32'h01, 32'h0,        32'h12345678, 32'h0,        1'b1, 1, 0, 32'h0};
    vecs[10] = '{1'b1, 3'b100, 32'h20, 32'h55555555, 32'h12345678, 32'h0,        1'b1, 1, 0, 32'h0};
    vecs[11] = '{1'b0, 3'b011, 32'h20, 32'h0,        32'h12345678, 32'h0,        1'b1, 1, 0, 32'h0};
    vecs[12] = '{1'b1, F3_SH,  32'h23, 32'h0000BEEF, 32'h12345678, 32'h0,        1'b1, 1, 0, 32'h0};
    vecs[13] = '{1'b0, F3_LHU, 32'h03, 32'h0,        32'h12345678, 32'h0,        1'b1, 1, 0, 32'h0};

    for (int i = 0; i < 14; i++) begin
      preload(int'(vecs[i].addr >> 2), vecs[i].init);
      applyStimulus(vecs[i].is_write, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b0);
      checkOutput($sformatf("vec%0d resp latency", i), obs_lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d rdata", i), obs_rdata, vecs[i].rdata);
      checkOutput($sformatf("vec%0d err", i), {31'h0, obs_err}, {31'h0, vecs[i].err});
      checkOutput($sformatf("vec%0d write count", i), obs_wr_cnt, (vecs[i].wr_lat != 0) ? 1 : 0);
      checkOutput($sformatf("vec%0d write latency", i), obs_wr_lat, vecs[i].wr_lat);
      checkOutput($sformatf("vec%0d mem_din", i), obs_wr_din, vecs[i].din);
      if (!vecs[i].err)
        checkOutput($sformatf("vec%0d mem_addr held", i), {31'h0, obs_addr_ok}, 32'h1);
      checkOutput($sformatf("vec%0d single pulse", i), {31'h0, obs_post_valid}, 32'h0);
      checkOutput($sformatf("vec%0d ready after", i), {31'h0, obs_post_ready}, 32'h1);
    end

    // Reset during WAIT of a byte store: abort with no write and no response
    preload(10, 32'h11223344);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_SB;
    req_addr = 32'h29; req_wdata = 32'h000000EE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("abort mem_write", {31'h0, mem_write}, 32'h0);
    checkOutput("abort resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("abort mem_addr", mem_addr, 32'h0);
    bad = 0;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      if (mem_write || resp_valid) bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      if (mem_write || resp_valid) bad++;
    end
    checkOutput("abort quiet cycles", bad, 0);
    applyStimulus(1'b0, F3_LW, 32'h28, 32'h0, 1'b0);
    checkOutput("abort reload latency", obs_lat, 3);
    checkOutput("abort RAM untouched", obs_rdata, 32'h11223344);
    applyStimulus(1'b0, F3_LBU, 32'h29, 32'h0, 1'b0);
    checkOutput("abort next LBU", obs_rdata, 32'h00000033);

    // Randomized run against the reference memory model
    for (int i = 0; i < 64; i++) begin
      refmem[i] = $urandom;
      preload(i, refmem[i]);
    end
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      wd = $urandom;
      refModel(w, f3, a, wd);
      applyStimulus(w, f3, a, wd, 1'b1);
      checkOutput($sformatf("rnd%0d latency", i), obs_lat, exp_lat);
      checkOutput($sformatf("rnd%0d rdata", i), obs_rdata, exp_rdata);
      checkOutput($sformatf("rnd%0d err", i), {31'h0, obs_err}, {31'h0, exp_err});
      checkOutput($sformatf("rnd%0d write count", i), obs_wr_cnt, exp_wr_cnt);
      if (exp_wr_cnt == 1) begin
        checkOutput($sformatf("rnd%0d write latency", i), obs_wr_lat, exp_wr_lat);
        checkOutput($sformatf("rnd%0d mem_din", i), obs_wr_din, exp_din);
      end
      if (!exp_err)
        checkOutput($sformatf("rnd%0d mem_addr held", i), {31'h0, obs_addr_ok}, 32'h1);
      checkOutput($sformatf("rnd%0d single pulse", i), {31'h0, obs_post_valid}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WORD, default 32, meaning data width in bits; only WORD=32 is supported.
REQ-002 SHALL have parameter ADDR, default 32, meaning byte-address width and word-address width.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1: core issues an access.
REQ-006 SHALL have port req_ready, output, 1: unit can accept a request.
REQ-007 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3: RV32I width/sign code.
REQ-009 SHALL have port req_addr, input, ADDR: byte address.
REQ-010 SHALL have port req_wdata, input, WORD: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, WORD: extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1: misaligned or illegal access; valid with resp_valid.
REQ-014 SHALL have port mem_addr, output, ADDR: word address to data RAM, equal to req_addr >> 2.
REQ-015 SHALL have port mem_write, output, 1: RAM write strobe.
REQ-016 SHALL have port mem_din, output, WORD: RAM write data.
REQ-017 SHALL have port mem_dout, input, WORD: RAM read data, valid one cycle after a read address is presented with mem_write=0.

Function
REQ-018 SHALL implement states IDLE, RD, WAIT, WR, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL accept a request on a clk edge with req_valid=1 in IDLE (cycle T) and register addr, funct3, wdata and write.
REQ-020 SHALL flag an error on: load funct3 in {011,110,111}; store funct3 not in {000,001,010}; halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-021 SHALL go from IDLE to RESP on error (resp_valid, resp_err=1 at T+1) and perform no RAM access.
REQ-022 Loads SHALL sequence IDLE->RD->WAIT->RESP: read address at T+1, mem_dout captured at T+2, resp_valid at T+3.
REQ-023 Word stores SHALL sequence IDLE->WR->RESP: mem_write=1 with mem_din=wdata at T+1, resp_valid at T+2.
REQ-024 Byte/halfword stores SHALL perform read-modify-write via IDLE->RD->WAIT->WR->RESP, replacing only the addressed lane, with mem_write at T+3 and resp_valid at T+4.
REQ-025 SHALL select byte lane addr[1:0] and halfword lane addr[1] little-endian; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-026 SHALL assert mem_write only in WR, and exactly one cycle per store.
REQ-027 SHALL hold mem_addr stable from RD or WR until the return to IDLE.
REQ-028 SHALL assert resp_valid for exactly one cycle in RESP, with no backpressure, then return to IDLE.
REQ-029 SHALL ignore req_valid outside IDLE; back-to-back requests are accepted on the cycle after RESP.

Reset
REQ-030 On rst_n=0, SHALL asynchronously enter IDLE with resp_valid, resp_err, mem_write=0 and resp_rdata, mem_addr, mem_din=0.
REQ-031 Reset asserted mid-operation SHALL abort the access with no further mem_write and no response; RAM contents already written stay undefined to the core.

Structure
REQ-032 SHALL take the funct3 codes (LB/LH/LW/LBU/LHU, SB/SH/SW) and the state encoding from a shared package, lsu_pkg.
REQ-033 SHALL place lane extraction, extension and store merging in one combinational sub-module, lsu_align.

Verification
REQ-034 LW at 0x10 with RAM[4]=0xDEADBEEF -> mem_addr=4 at T+1; resp_valid at T+3; rdata=0xDEADBEEF; err=0.
REQ-035 LB at 0x13 and LBU at 0x13 with RAM[4]=0x80FF0011 -> rdata 0xFFFFFF80 and 0x00000080.
REQ-036 SH 0xABCD at 0x22 with RAM[8]=0x11223344 -> mem_write at T+3 with mem_din=0xABCD3344; resp at T+4.
REQ-037 LW at 0x06, LH at 0x01, and store funct3=100 -> resp_err=1 at T+1; mem_write never asserted.
REQ-038 rst_n pulled low in WAIT of an SB -> IDLE immediately; no mem_write; no resp_valid; next request served normally.
